// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer advanced by a one-cycle tick enable.
// Optional TIMER_BLINK_EN builds a display-blank toggle that flashes while expired.
module bcd_countdown_timer #(
    parameter int MAX_MIN_TENS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       start_stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       blank
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    state_t     state, state_nxt;
    logic [3:0] mt, mo, st, so;
    logic [3:0] mt_nxt, mo_nxt, st_nxt, so_nxt;
    logic       done_q, done_nxt;
    logic       is_zero, is_one;

    assign is_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
    assign is_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        mt_nxt    = mt;
        mo_nxt    = mo;
        st_nxt    = st;
        so_nxt    = so;
        done_nxt  = 1'b0;

        if (load) begin
            mt_nxt    = (ld_min_tens > MT_MAX) ? MT_MAX : ld_min_tens;
            mo_nxt    = (ld_min_ones > 4'd9)   ? 4'd9   : ld_min_ones;
            st_nxt    = (ld_sec_tens > 4'd5)   ? 4'd5   : ld_sec_tens;
            so_nxt    = (ld_sec_ones > 4'd9)   ? 4'd9   : ld_sec_ones;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (start_stop && !is_zero) state_nxt = RUN;
                RUN: begin
                    if (start_stop) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        // Borrow chain; 00:00 never reaches here, so min_tens cannot wrap.
                        if (so != 4'd0) begin
                            so_nxt = so - 4'd1;
                        end else begin
                            so_nxt = 4'd9;
                            if (st != 4'd0) begin
                                st_nxt = st - 4'd1;
                            end else begin
                                st_nxt = 4'd5;
                                if (mo != 4'd0) begin
                                    mo_nxt = mo - 4'd1;
                                end else begin
                                    mo_nxt = 4'd9;
                                    mt_nxt = mt - 4'd1;
                                end
                            end
                        end
                        if (is_one) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                PAUSE: if (start_stop) state_nxt = RUN;
                DONE:  if (start_stop) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mt     <= 4'd0;
            mo     <= 4'd0;
            st     <= 4'd0;
            so     <= 4'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            mt     <= mt_nxt;
            mo     <= mo_nxt;
            st     <= st_nxt;
            so     <= so_nxt;
            done_q <= done_nxt;
        end
    end

`ifdef TIMER_BLINK_EN
    logic blank_q;

    // Toggles only while remaining in DONE; entry, exit and load all leave it clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else if ((state == DONE) && (state_nxt == DONE)) begin
            if (tick) blank_q <= ~blank_q;
        end else begin
            blank_q <= 1'b0;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign min_tens = mt;
    assign min_ones = mo;
    assign sec_tens = st;
    assign sec_ones = so;
    assign running  = (state == RUN);
    assign expired  = (state == DONE);
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random
// stimulus against a total-seconds reference model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_min_tens = 4'd0;
    logic [3:0] ld_min_ones = 4'd0;
    logic [3:0] ld_sec_tens = 4'd0;
    logic [3:0] ld_sec_ones = 4'd0;
    logic       start_stop = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, expired, blank;
    logic [15:0] digits;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TIMER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    // Reference model: remaining time as plain seconds plus a mode number
    // (0 holding, 1 counting, 2 paused, 3 expired).
    int m_total = 0;
    int m_mode  = 0;
    bit m_done  = 1'b0;
    bit m_blank = 1'b0;

    bcd_countdown_timer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
        .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
        .start_stop(start_stop),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done), .expired(expired), .blank(blank)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    function automatic int clampd(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] model_digits();
        return {4'(m_total / 600), 4'((m_total / 60) % 10),
                4'((m_total % 60) / 10), 4'(m_total % 10)};
    endfunction

    task automatic model_reset();
        m_total = 0; m_mode = 0; m_done = 1'b0; m_blank = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [15:0] v, input bit ss, input bit tk);
        m_done = 1'b0;
        if (ld) begin
            m_total = clampd(int'(v[15:12]), 9) * 600 + clampd(int'(v[11:8]), 9) * 60
                    + clampd(int'(v[7:4]), 5) * 10 + clampd(int'(v[3:0]), 9);
            m_mode  = 0;
            m_blank = 1'b0;
        end else begin
            case (m_mode)
                0: if (ss && m_total != 0) m_mode = 1;
                1: if (ss) m_mode = 2;
                   else if (tk) begin
                       m_total = m_total - 1;
                       if (m_total == 0) begin m_mode = 3; m_done = 1'b1; m_blank = 1'b0; end
                   end
                2: if (ss) m_mode = 1;
                default: if (ss) begin m_mode = 0; m_blank = 1'b0; end
                         else if (tk && BLINK) m_blank = ~m_blank;
            endcase
        end
    endtask

    // One clock: inputs driven at the falling edge, strobes dropped and model advanced just after the rising edge.
    task automatic step(input bit ld, input logic [15:0] v, input bit ss, input bit tk);
        @(negedge clk);
        load = ld; start_stop = ss; tick = tk;
        {ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones} = v;
        @(posedge clk);
        #1;
        load = 1'b0; start_stop = 1'b0; tick = 1'b0;
        model_step(ld, v, ss, tk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (digits !== 16'h0000) begin
            n_fail++; $display("FAIL reset_digits: got %h want 0000", digits);
        end
        n_checks++;
        if ({running, done, expired, blank} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {running, done, expired, blank});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        bit saw_done = 1'b0;
        step(1'b1, 16'h0105, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1);
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (digits !== 16'h0059) begin n_fail++; $display("FAIL count_digits: got %h want 0059", digits); end
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL count_running: got %b want 1", running); end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL count_no_done: got %b want 0", saw_done); end
    endtask

    task automatic test_expiry();
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if ({digits, done} !== {16'h0001, 1'b0}) begin
            n_fail++; $display("FAIL expiry_first_tick: got %h/%b want 0001/0", digits, done);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if ({digits, done, expired, running} !== {16'h0000, 3'b110}) begin
            n_fail++; $display("FAIL expiry_edge: got %h d%b e%b r%b want 0000 d1 e1 r0", digits, done, expired, running);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        n_checks++;
        if ({done, expired} !== 2'b01) begin
            n_fail++; $display("FAIL expiry_pulse_width: got d%b e%b want d0 e1", done, expired);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if ({digits, expired, running} !== {16'h0000, 2'b00}) begin
            n_fail++; $display("FAIL expiry_ack: got %h e%b r%b want 0000 e0 r0", digits, expired, running);
        end
    endtask

    task automatic test_clamp();
        step(1'b1, 16'h1000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if (digits !== 16'h0959) begin n_fail++; $display("FAIL borrow_chain: got %h want 0959", digits); end
        step(1'b1, 16'h9F7C, 1'b0, 1'b0);
        n_checks++;
        if ({digits, running} !== {16'h9959, 1'b0}) begin
            n_fail++; $display("FAIL clamp_load: got %h r%b want 9959 r0", digits, running);
        end
    endtask

    task automatic test_pause();
        step(1'b1, 16'h0030, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        n_checks++;
        if ({digits, running} !== {16'h0030, 1'b0}) begin
            n_fail++; $display("FAIL pause_wins: got %h r%b want 0030 r0", digits, running);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if (digits !== 16'h0030) begin n_fail++; $display("FAIL pause_hold: got %h want 0030", digits); end
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        n_checks++;
        if ({digits, running} !== {16'h0030, 1'b1}) begin
            n_fail++; $display("FAIL resume_no_dec: got %h r%b want 0030 r1", digits, running);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if (digits !== 16'h0027) begin n_fail++; $display("FAIL resume_count: got %h want 0027", digits); end
    endtask

    task automatic test_zero_and_reset();
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if ({running, expired} !== 2'b00) begin
            n_fail++; $display("FAIL zero_start: got r%b e%b want r0 e0", running, expired);
        end
        step(1'b1, 16'h0520, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if ({digits, running} !== {16'h0517, 1'b1}) begin
            n_fail++; $display("FAIL pre_reset: got %h r%b want 0517 r1", digits, running);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({digits, running, done, expired, blank} !== {16'h0000, 4'b0000}) begin
            n_fail++; $display("FAIL async_reset: got %h flags %b want 0000 flags 0000",
                               digits, {running, done, expired, blank});
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_blink();
        bit [2:0] want = BLINK ? 3'b101 : 3'b000;
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++;
        if ({expired, blank} !== 2'b10) begin
            n_fail++; $display("FAIL blink_entry: got e%b b%b want e1 b0", expired, blank);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1);
            n_checks++;
            if (blank !== want[2 - i]) begin
                n_fail++; $display("FAIL blink_tick%0d: got %b want %b", i, blank, want[2 - i]);
            end
        end
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        n_checks++;
        if ({blank, expired, digits} !== {2'b00, 16'h0100}) begin
            n_fail++; $display("FAIL blink_load_clear: got b%b e%b %h want b0 e0 0100", blank, expired, digits);
        end
    endtask

    task automatic test_random();
        bit          ld, ss, tk;
        logic [15:0] v;
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 24) == 0);
            ss = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1)
                v = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            else
                v = 16'($urandom);
            step(ld, v, ss, tk);
            n_checks++;
            if ({digits, running, done, expired, blank} !==
                {model_digits(), m_mode == 1, m_done, m_mode == 3, m_blank}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h r%b d%b e%b b%b want %h r%b d%b e%b b%b",
                         i, digits, running, done, expired, blank,
                         model_digits(), m_mode == 1, m_done, m_mode == 3, m_blank);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_expiry();
        test_clamp();
        test_pause();
        test_zero_and_reset();
        test_blink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
